// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [2:0] {
    WAIT_FOR_START       = 3'd0,
    CHECK_DIVIDE_BY_ZERO = 3'd1,
    SHIFT_LEFT           = 3'd2,
    SHIFT_RIGHT          = 3'd3,
    NO_ERROR             = 3'd4,
    ERROR                = 3'd5
  } state_e;

  localparam int WIDTH_DEFAULT = 8;

  // Shift counter width; must hold WIDTH-1 and never collapse to zero bits.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEFAULT);

endpackage

// File: rtl/divider_control.sv
// Control FSM for seq_divider: sequences normalise (left) and subtract (right) phases.
module divider_control
  import divider_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cnt_is_0,
  input  logic divisor_is_0,
  input  logic dvsr_less_than_dvnd,
  input  logic shifted_divisor_msb,
  output logic error,
  output logic done,
  output logic init,
  output logic left,
  output logic right,
  output logic sub
);

  state_e state_r;
  state_e next_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_FOR_START;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; unused encodings fall back to idle
  always_comb begin
    next_s = state_r;
    case (state_r)
      WAIT_FOR_START: begin
        if (start) next_s = CHECK_DIVIDE_BY_ZERO;
        else       next_s = WAIT_FOR_START;
      end
      CHECK_DIVIDE_BY_ZERO: begin
        if (divisor_is_0) next_s = ERROR;
        else              next_s = SHIFT_LEFT;
      end
      SHIFT_LEFT: begin
        if (shifted_divisor_msb || !dvsr_less_than_dvnd) next_s = SHIFT_RIGHT;
        else                                            next_s = SHIFT_LEFT;
      end
      SHIFT_RIGHT: begin
        if (cnt_is_0) next_s = NO_ERROR;
        else          next_s = SHIFT_RIGHT;
      end
      NO_ERROR: next_s = WAIT_FOR_START;
      ERROR:    next_s = WAIT_FOR_START;
      default:  next_s = WAIT_FOR_START;
    endcase
  end

  // Datapath strobes and status outputs
  always_comb begin
    init  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    sub   = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    case (state_r)
      WAIT_FOR_START: init = start;
      CHECK_DIVIDE_BY_ZERO: init = 1'b0;
      SHIFT_LEFT: left = !shifted_divisor_msb && dvsr_less_than_dvnd;
      SHIFT_RIGHT: begin
        sub   = 1'b1;
        right = !cnt_is_0;
      end
      NO_ERROR: done = 1'b1;
      ERROR: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: done = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: datapath registers and comparators,
// sequenced by divider_control.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             error
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CW-1:0]    cnt_r;

  logic init_s, left_s, right_s, sub_s;
  logic cnt_is_0_s, divisor_is_0_s, dvsr_le_rem_s, dvsr_msb_s;

  assign cnt_is_0_s     = (cnt_r == '0);
  assign divisor_is_0_s = (dvsr_r == '0);
  // Doubles as "subtraction succeeds" during the right phase
  assign dvsr_le_rem_s  = (dvsr_r <= rem_r);
  assign dvsr_msb_s     = dvsr_r[WIDTH-1];

  divider_control u_control (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .cnt_is_0            (cnt_is_0_s),
    .divisor_is_0        (divisor_is_0_s),
    .dvsr_less_than_dvnd (dvsr_le_rem_s),
    .shifted_divisor_msb (dvsr_msb_s),
    .error               (error),
    .done                (done),
    .init                (init_s),
    .left                (left_s),
    .right               (right_s),
    .sub                 (sub_s)
  );

  // Datapath registers; a zero divisor preloads the all-ones error quotient
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr_r <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
    end else if (init_s) begin
      dvsr_r <= divisor;
      rem_r  <= dividend;
      quo_r  <= (divisor == '0) ? '1 : '0;
      cnt_r  <= '0;
    end else begin
      if (left_s) begin
        dvsr_r <= dvsr_r << 1;
        cnt_r  <= cnt_r + CNT_ONE;
      end else if (right_s) begin
        dvsr_r <= dvsr_r >> 1;
        cnt_r  <= cnt_r - CNT_ONE;
      end
      if (sub_s) begin
        quo_r <= {quo_r[WIDTH-2:0], dvsr_le_rem_s};
        if (dvsr_le_rem_s) begin
          rem_r <= rem_r - dvsr_r;
        end
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of normalising left shifts the divider performs for b into a.
  function automatic int left_shifts(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    int k;
    d = b;
    k = 0;
    while (d[7] == 1'b0 && d <= a && d != 8'd0) begin
      d = d << 1;
      k++;
    end
    return k;
  endfunction

  // Called #1 after a rising edge. Latency counts edges after the start-sampling edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ee, input int elat);
    int n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 8'd1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, done ? n : -1, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " error"}, error, ee);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " error one cycle"}, error, 1'b0);
  endtask

  initial begin
    int seen_done;
    int first_done;
    int second_done;
    int n;
    logic [7:0] a;
    logic [7:0] b;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #1;
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset quotient", quotient, 8'd0);
    check("reset remainder", remainder, 8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("idle done", done, 1'b0);

    // Latency is 2k+3 for k normalising shifts; a zero divisor finishes on the second edge.
    run_op("7/2",     8'd7,   8'd2,   8'd3,   8'd1,   1'b0, 7);
    run_op("255/1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 17);
    run_op("0/5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 3);
    run_op("200/0",   8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1);
    run_op("4/4",     8'd4,   8'd4,   8'd1,   8'd0,   1'b0, 5);
    run_op("1/255",   8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 3);
    run_op("128/128", 8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 3);
    run_op("200/7",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 13);
    run_op("0/0",     8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1);
    check("result holds", quotient, 8'd255);

    // Reset during SHIFT_RIGHT of 100/3, with ignored start pulses while busy
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3 || i == 6) begin
        dividend = 8'd5;
        divisor  = 8'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort quotient", quotient, 8'd0);
    check("abort remainder", remainder, 8'd0);
    check("abort done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("no done before restart", seen_done, 0);
    run_op("100/3", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 15);

    // Start held high: second op starts the cycle after the first done pulse
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    first_done  = -1;
    second_done = -1;
    n = 0;
    while (second_done < 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (first_done < 0) first_done = n;
        else second_done = n;
      end
    end
    start = 1'b0;
    check("held first done", first_done, 7);
    check("held second done", second_done, 16);
    check("held quotient", quotient, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held idle after drop", done, 1'b0);

    // Random sweep against / and %
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 5 == 4) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) run_op("rand div0", a, b, 8'd255, a, 1'b1, 1);
      else run_op("rand", a, b, a / b, a % b, 1'b0, 2 * left_shifts(a, b) + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
